// File: rtl/mips_cpu_mult_pkg.sv
// Shared types and helpers for the sequential MULT/MULTU engine.
package mips_cpu_mult_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } mult_state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    localparam int unsigned DefaultWidth    = 32;
    localparam int unsigned DefaultCntWidth = cnt_width(DefaultWidth);

endpackage

// File: rtl/mips_cpu_multiplier_seq.sv
// Radix-2 shift-add multiplier producing {HI, LO} for MULT/MULTU with a start/busy/done handshake.
// Signed requests are honoured only when MIPS_MULT_SIGNED_EN is defined.
module mips_cpu_multiplier_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);
    import mips_cpu_mult_pkg::*;

    localparam int unsigned CntW = cnt_width(WIDTH);

    mult_state_e          state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   out_q, out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 req_neg;
    logic [WIDTH:0]       sum;

`ifdef MIPS_MULT_SIGNED_EN
    // The most negative value negates to itself, which is already its correct magnitude.
    always_comb begin
        a_mag   = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag   = (is_signed && b[WIDTH-1]) ? -b : b;
        req_neg = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;

    always_comb begin
        a_mag   = a;
        b_mag   = b;
        req_neg = 1'b0;
    end
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        out_d    = out_q;
        sum      = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = req_neg;
                    acc_d    = '0;
                    cnt_d    = CntW'(WIDTH);
                    state_d  = StRun;
                end
            end
            StRun: begin
                // Carry out of the upper-half add becomes the new MSB after the shift.
                sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                         + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                out_d   = neg_q ? -acc_q : acc_q;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_mips_cpu_multiplier_seq.sv
// Scoreboard bench for mips_cpu_multiplier_seq at WIDTH=32; expectations follow MIPS_MULT_SIGNED_EN.
module tb_mips_cpu_multiplier_seq;

    localparam int unsigned W   = 32;
    localparam int unsigned Lat = W + 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            is_signed = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  out;

    int              n_checks = 0;
    int              n_fail = 0;
    int              done_cnt = 0;
    int              exp_done_cnt = 0;
    logic [2*W-1:0]  sb[$];

    mips_cpu_multiplier_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
        logic [63:0] ex;
        logic [63:0] ey;
        ex = {32'h0, x};
        ey = {32'h0, y};
`ifdef MIPS_MULT_SIGNED_EN
        if (s) begin
            ex = {{32{x[W-1]}}, x};
            ey = {{32{y[W-1]}}, y};
        end
`endif
        return ex * ey;
    endfunction

    // Every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) check_eq("unexpected_done", 64'd1, 64'd0);
            else check_eq("product", out, sb.pop_front());
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(negedge clk);
        a = x;
        b = y;
        is_signed = s;
        start = 1'b1;
        sb.push_back(model(x, y, s));
        exp_done_cnt++;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles after acceptance; optionally injects a start that must be ignored.
    task automatic wait_done(input string tag, input int inj_at, input bit idle_after);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < Lat + 20) begin
            @(negedge clk);
            n++;
            if (n == 1) check_eq({tag, "_busy_rise"}, 64'(busy), 64'd1);
            if (inj_at != 0 && n == inj_at) begin
                a = 32'h1234_5678;
                b = 32'h0000_0077;
                is_signed = 1'b1;
                start = 1'b1;
            end
            if (inj_at != 0 && n == inj_at + 1) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                check_eq({tag, "_busy_in_done"}, 64'(busy), 64'd1);
            end
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, seen ? 64'(n) : 64'hFFFF, 64'(Lat));
        if (idle_after) begin
            @(negedge clk);
            check_eq({tag, "_busy_fall"}, 64'(busy), 64'd0);
            check_eq({tag, "_done_fall"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [W-1:0] rx;
        logic [W-1:0] ry;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_out", out, 64'd0);

        issue(32'd3, 32'd5, 1'b0);
        wait_done("u3x5", 0, 1'b1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("umax", 0, 1'b1);
        issue(32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_done("sneg1x2", 0, 1'b1);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done("sminsq", 0, 1'b1);
        issue(32'h8000_0000, 32'd1, 1'b1);
        wait_done("sminx1", 0, 1'b1);
        issue(32'd7, 32'hFFFF_FFFD, 1'b1);
        wait_done("s7xm3", 0, 1'b0);

        // Back-to-back: start in the cycle right after done.
        issue(32'h0001_0000, 32'h0001_0000, 1'b0);
        wait_done("b2b", 0, 1'b1);

        issue(32'hDEAD_BEEF, 32'h0000_0010, 1'b0);
        wait_done("ignore", 10, 1'b1);
        repeat (40) @(negedge clk);
        check_eq("ignore_done_count", 64'(done_cnt), 64'(exp_done_cnt));

        // Reset mid-operation drops the request.
        issue(32'h0000_1111, 32'h0000_2222, 1'b0);
        n = 0;
        while (n < 15) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        void'(sb.pop_back());
        exp_done_cnt--;
        @(negedge clk);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_done", 64'(done), 64'd0);
        check_eq("midrst_out", out, 64'd0);
        issue(32'h0000_0101, 32'h0000_0303, 1'b0);
        wait_done("after_rst", 0, 1'b1);

        // Start coincident with reset is dropped.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        a = 32'd9;
        b = 32'd9;
        @(posedge clk);
        #1 begin
            reset = 1'b0;
            start = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst_start_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 6; i++) begin
            rx = $urandom;
            ry = $urandom;
            issue(rx, ry, 1'(i % 2));
            wait_done("rand", 0, 1'b0);
        end

        repeat (40) @(negedge clk);
        check_eq("done_count", 64'(done_cnt), 64'(exp_done_cnt));
        check_eq("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_multiplier_seq.md
# mips_cpu_multiplier_seq

Parametrised iterative multiplier for the MIPS CPU datapath, producing the full double-width product for MULT/MULTU into HI/LO. It replaces the single-cycle product with a radix-2 shift-add engine of configurable operand width. A start/busy/done handshake lets the control FSM stall HI/LO readers (MFHI/MFLO) until the result is ready. Signed operation is selected per request.

## Interface
- WIDTH, 32, operand width in bits; product width is 2*WIDTH. Legal values: 8..64, even.
- clk  in  1  rising-edge clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; accepted only in IDLE.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; out is valid from this cycle.
- out  out  2*WIDTH  product {HI, LO}; held until the next completion.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: on start=1, latch |a|, |b| (magnitudes when is_signed=1, raw otherwise), latch neg = is_signed & (a[MSB] ^ b[MSB]), clear accumulator, load counter = WIDTH, go to RUN.
- RUN: each cycle, if multiplier LSB = 1 add multiplicand into accumulator upper half with carry; shift {carry, acc} right by 1; decrement counter; at counter = 1 go to FIX.
- FIX: out <= neg ? -acc : acc (2*WIDTH two's complement); go to DONE.
- DONE: done = 1 for exactly this cycle; return to IDLE.
- Magnitude of the most negative operand (e.g. 0x8000_0000) is its unsigned bit pattern; no overflow possible in 2*WIDTH result.
- start while busy=1 or in DONE: ignored, no queuing; operands not re-sampled.
- start in the same cycle as reset: reset wins, request dropped.
- Reset (any state): state = IDLE, busy = 0, done = 0, out = 0, counter and accumulator cleared.

## Timing
- Start accepted at edge T0 (start=1 in IDLE).
- busy = 1 from T0+1 through T0+WIDTH+2 inclusive; busy = 0 in IDLE only.
- RUN occupies WIDTH cycles, FIX one, DONE one: done pulses at T0+WIDTH+2 (34 cycles for WIDTH=32).
- out updates at the FIX→DONE edge and is stable while done=1 and afterwards.
- Earliest back-to-back start: cycle after done (T0+WIDTH+3).
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- MIPS_MULT_SIGNED_EN defined: is_signed honoured as above (magnitude conversion and FIX negation present).
- Not defined: is_signed ignored, all requests unsigned, neg forced to 0; FIX still occupies one cycle so latency is identical in both builds.

## Structure
- Package mips_cpu_mult_pkg: state enum (IDLE, RUN, FIX, DONE), localparam for counter width $clog2(WIDTH+1) via function.
- No sub-module required; magnitude/negation is inline combinational logic. Single module of roughly 150 lines.

## Test plan
- WIDTH=32, unsigned a=3, b=5, start at T0 -> done at T0+34, out = 0x0000_0000_0000_000F, busy low next cycle.
- Unsigned a=b=0xFFFF_FFFF -> out = 0xFFFF_FFFE_0000_0001.
- Signed a=0xFFFF_FFFF (-1), b=2 -> out = 0xFFFF_FFFF_FFFF_FFFE; without MIPS_MULT_SIGNED_EN -> 0x0000_0001_FFFF_FFFE.
- Signed a=b=0x8000_0000 -> out = 0x4000_0000_0000_0000; signed a=0x8000_0000, b=1 -> 0xFFFF_FFFF_8000_0000.
- start=1 again at T0+10 with different operands -> ignored, first result delivered unchanged at T0+34, no second done.
- reset=1 at T0+15 for one cycle -> busy=0, done=0, out=0 next cycle; no done pulse follows; new start at T0+17 completes at T0+51.
